// File: rtl/m68k_dram_arbiter.sv
// m68k_dram_arbiter: shares one 68k-style DRAM controller port between the
// 68000 CPU and a DMA/video-fetch master.
//
// Arbitration: the CPU has priority. A DMA request wins against a pending
// CPU request only if it has already waited through at least one CPU cycle.
// The run counter counts completed DMA cycles since the last CPU cycle and
// saturates at MAX_DMA_RUN. Once it is saturated, a pending CPU request
// always wins.
//
// Every cycle ends with one RELEASE clock in which all controller strobes
// are high. This lets the controller return to idle before the next
// access starts.
//
// Optional build macro ARB_STATS_EN adds two 32-bit counters of completed
// CPU and DMA cycles (Cpu_Grant_Count, Dma_Grant_Count).
module m68k_dram_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MAX_DMA_RUN = 4
) (
  input  logic              Clock,
  input  logic              Reset_L,
  input  logic [ADDR_W-1:0] Cpu_Address,
  input  logic [15:0]       Cpu_DataIn,
  input  logic              Cpu_AS_L,
  input  logic              Cpu_DramSelect_L,
  input  logic              Cpu_UDS_L,
  input  logic              Cpu_LDS_L,
  input  logic              Cpu_WE_L,
  output logic              Cpu_Dtack_L,
  output logic [15:0]       Cpu_DataOut,
  input  logic              Dma_Req_H,
  input  logic              Dma_WE_L,
  input  logic [ADDR_W-1:0] Dma_Address,
  input  logic [15:0]       Dma_DataIn,
  output logic              Dma_Ack_H,
  output logic [15:0]       Dma_DataOut,
  output logic [ADDR_W-1:0] Ctl_Address,
  output logic [15:0]       Ctl_DataIn,
  output logic              Ctl_AS_L,
  output logic              Ctl_DramSelect_L,
  output logic              Ctl_UDS_L,
  output logic              Ctl_LDS_L,
  output logic              Ctl_WE_L,
  input  logic              Ctl_Dtack_L,
  input  logic [15:0]       Ctl_DataOut,
  input  logic              Ctl_ResetOut_L,
  output logic [1:0]        Grant
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       Cpu_Grant_Count,
  output logic [31:0]       Dma_Grant_Count
`endif
);

  localparam int unsigned RUN_W = (MAX_DMA_RUN < 1) ? 1 : $clog2(MAX_DMA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DMA_RUN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_CYC = 2'd1,
    DMA_CYC = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic             dma_waited;  // DMA was pending during a CPU cycle
  logic             cpu_req;
  logic             dma_pick;

  assign cpu_req = ~Cpu_AS_L & ~Cpu_DramSelect_L;

  // Decide whether a DMA request takes the next slot over the CPU
  always_comb begin
    dma_pick = 1'b0;
    if (Dma_Req_H) begin
      if (!cpu_req)
        dma_pick = 1'b1;
      else if (dma_waited && (run_cnt != RUN_MAX))
        dma_pick = 1'b1;
    end
  end

  // Arbiter FSM with registered controller strobes, acks and grant
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state       <= IDLE;
      Grant       <= 2'b00;
      run_cnt     <= '0;
      dma_waited  <= 1'b0;
      {Ctl_AS_L, Ctl_DramSelect_L, Ctl_UDS_L, Ctl_LDS_L, Ctl_WE_L} <= '1;
      Ctl_Address <= '0;
      Ctl_DataIn  <= '0;
      Cpu_Dtack_L <= 1'b1;
      Cpu_DataOut <= '0;
      Dma_Ack_H   <= 1'b0;
      Dma_DataOut <= '0;
`ifdef ARB_STATS_EN
      Cpu_Grant_Count <= '0;
      Dma_Grant_Count <= '0;
`endif
    end else begin
      Dma_Ack_H <= 1'b0;
      case (state)
        IDLE: begin
          // Strobes are already high here; they go low one clock after the grant
          if (Ctl_ResetOut_L) begin
            if (dma_pick) begin
              state      <= DMA_CYC;
              Grant      <= 2'b10;
              dma_waited <= 1'b0;
            end else if (cpu_req) begin
              state <= CPU_CYC;
              Grant <= 2'b01;
            end
          end
        end

        CPU_CYC: begin
          if (Dma_Req_H)
            dma_waited <= 1'b1;
          if (!Ctl_ResetOut_L) begin
            {Ctl_AS_L, Ctl_DramSelect_L, Ctl_UDS_L, Ctl_LDS_L, Ctl_WE_L} <= '1;
            Cpu_Dtack_L <= 1'b1;
            Grant       <= 2'b00;
            state       <= IDLE;
          end else if (!cpu_req) begin
            // The CPU ended the access, or aborted it before Dtack
            {Ctl_AS_L, Ctl_DramSelect_L, Ctl_UDS_L, Ctl_LDS_L, Ctl_WE_L} <= '1;
            Cpu_Dtack_L <= 1'b1;
            Grant       <= 2'b00;
            run_cnt     <= '0;
            state       <= RELEASE;
`ifdef ARB_STATS_EN
            if (!Cpu_Dtack_L)
              Cpu_Grant_Count <= Cpu_Grant_Count + 32'd1;
`endif
          end else begin
            Ctl_AS_L         <= Cpu_AS_L;
            Ctl_DramSelect_L <= Cpu_DramSelect_L;
            Ctl_UDS_L        <= Cpu_UDS_L;
            Ctl_LDS_L        <= Cpu_LDS_L;
            Ctl_WE_L         <= Cpu_WE_L;
            Ctl_Address      <= Cpu_Address;
            Ctl_DataIn       <= Cpu_DataIn;
            // Capture the read data once and hold it until the CPU drops AS
            if (!Ctl_AS_L && !Ctl_Dtack_L && Cpu_Dtack_L) begin
              Cpu_Dtack_L <= 1'b0;
              Cpu_DataOut <= Ctl_DataOut;
            end
          end
        end

        DMA_CYC: begin
          if (!Ctl_ResetOut_L) begin
            {Ctl_AS_L, Ctl_DramSelect_L, Ctl_UDS_L, Ctl_LDS_L, Ctl_WE_L} <= '1;
            Grant <= 2'b00;
            state <= IDLE;
          end else if (!Ctl_AS_L && !Ctl_Dtack_L) begin
            {Ctl_AS_L, Ctl_DramSelect_L, Ctl_UDS_L, Ctl_LDS_L, Ctl_WE_L} <= '1;
            Dma_DataOut <= Ctl_DataOut;
            Dma_Ack_H   <= 1'b1;
            Grant       <= 2'b00;
            state       <= RELEASE;
            if (run_cnt != RUN_MAX)
              run_cnt <= run_cnt + 1'b1;
`ifdef ARB_STATS_EN
            Dma_Grant_Count <= Dma_Grant_Count + 32'd1;
`endif
          end else begin
            Ctl_AS_L         <= 1'b0;
            Ctl_DramSelect_L <= 1'b0;
            Ctl_UDS_L        <= 1'b0;
            Ctl_LDS_L        <= 1'b0;
            Ctl_WE_L         <= Dma_WE_L;
            Ctl_Address      <= Dma_Address;
            Ctl_DataIn       <= Dma_DataIn;
          end
        end

        RELEASE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
